// File: rtl/mem_init_pkg.sv
// Shared types and constants for the memory init loader.
package mem_init_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL0,
    FILL1,
    WR_PAIR,
    WR_SINGLE,
    DONE
  } state_t;

  localparam int unsigned MEM_BYTES   = 4096;
  localparam logic [3:0]  WR_ALL      = 4'b1111;
  localparam logic [3:0]  WR_NONE     = 4'b0000;
  localparam int unsigned PAIR_STRIDE = 8;

endpackage

// File: rtl/mem_init_loader.sv
// Pairs streamed words and fills a memory region using dual-word init writes.
// Optional `MEM_INIT_CSUM_EN adds a running checksum output of accepted words.
module mem_init_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = mem_init_pkg::MEM_BYTES
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [10:0]       word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain1,
  output logic [DATA_W-1:0] mem_datain2,
  output logic [3:0]        mem_wr,
  output logic              mem_enable_load,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef MEM_INIT_CSUM_EN
  ,
  output logic [31:0]       csum
`endif
);
  import mem_init_pkg::*;

  // Two spare bits so even an out-of-range word_count cannot wrap the end address.
  localparam int unsigned ChkW = ADDR_W + 2;

  state_t            state_q, state_d;
  logic [10:0]       remaining_q, remaining_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] word0_q, word0_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic [3:0]        wr_q, wr_d;
  logic              load_q, load_d;
  logic              err_q, err_d;
  logic [ChkW-1:0]   end_addr;
  logic              reject;
  logic              accept;
`ifdef MEM_INIT_CSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  assign end_addr = ChkW'(base_addr) + ChkW'({word_count, 2'b00});
  assign reject   = (base_addr[1:0] != 2'b00) || (end_addr > ChkW'(MEM_BYTES));
  assign in_ready = (state_q == FILL0) || (state_q == FILL1);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    word0_d     = word0_q;
    maddr_d     = maddr_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    wr_d        = WR_NONE;
    load_d      = 1'b0;
    err_d       = 1'b0;
`ifdef MEM_INIT_CSUM_EN
    csum_d      = accept ? csum_q + 32'(in_data) : csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            remaining_d = word_count;
            addr_d      = base_addr;
            state_d     = (word_count == 11'd0) ? DONE : FILL0;
`ifdef MEM_INIT_CSUM_EN
            csum_d      = 32'd0;
`endif
          end
        end
      end
      FILL0: begin
        if (in_valid) begin
          word0_d     = in_data;
          remaining_d = remaining_q - 11'd1;
          if (remaining_q >= 11'd2) begin
            state_d = FILL1;
          end else begin
            // Odd trailing word: plain single-port write.
            state_d = WR_SINGLE;
            maddr_d = addr_q;
            data1_d = in_data;
            wr_d    = WR_ALL;
          end
        end
      end
      FILL1: begin
        if (in_valid) begin
          remaining_d = remaining_q - 11'd1;
          state_d     = WR_PAIR;
          maddr_d     = addr_q;
          data1_d     = word0_q;
          data2_d     = in_data;
          wr_d        = WR_ALL;
          load_d      = 1'b1;
        end
      end
      WR_PAIR: begin
        addr_d  = addr_q + ADDR_W'(PAIR_STRIDE);
        state_d = (remaining_q != 11'd0) ? FILL0 : DONE;
      end
      WR_SINGLE: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      word0_q     <= '0;
      maddr_q     <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      wr_q        <= WR_NONE;
      load_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_INIT_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      word0_q     <= word0_d;
      maddr_q     <= maddr_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      wr_q        <= wr_d;
      load_q      <= load_d;
      err_q       <= err_d;
`ifdef MEM_INIT_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem_address     = maddr_q;
  assign mem_datain1     = data1_q;
  assign mem_datain2     = data2_q;
  assign mem_wr          = wr_q;
  assign mem_enable_load = load_q;
  assign err             = err_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
`ifdef MEM_INIT_CSUM_EN
  assign csum            = csum_q;
`endif

endmodule

// File: tb/tb_mem_init_loader.sv
// Directed bench for mem_init_loader with a word-addressed memory model.
module tb_mem_init_loader;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        start;
  logic [11:0] base_addr;
  logic [10:0] word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [11:0] mem_address;
  logic [31:0] mem_datain1, mem_datain2;
  logic [3:0]  mem_wr;
  logic        mem_enable_load;
  logic        busy, done, err;
`ifdef MEM_INIT_CSUM_EN
  logic [31:0] csum;
`endif

  int checks = 0;
  int errors = 0;
  int write_cnt = 0;

  logic [31:0] mem [0:1023];
  logic        written [0:1023];

  mem_init_loader dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_address(mem_address), .mem_datain1(mem_datain1),
    .mem_datain2(mem_datain2), .mem_wr(mem_wr), .mem_enable_load(mem_enable_load),
    .busy(busy), .done(done), .err(err)
`ifdef MEM_INIT_CSUM_EN
    , .csum(csum)
`endif
  );

  always #5 Clk = ~Clk;

  // Memory model: commits whatever the loader presents, sampled mid-cycle.
  always @(negedge Clk) begin
    logic [11:0] a2;
    if (mem_wr != 4'b0000) begin
      write_cnt <= write_cnt + 1;
      mem[mem_address[11:2]]     <= mem_datain1;
      written[mem_address[11:2]] <= 1'b1;
      if (mem_enable_load) begin
        a2 = mem_address + 12'd4;
        mem[a2[11:2]]     <= mem_datain2;
        written[a2[11:2]] <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] init_pat(input logic [11:0] a);
    return 32'h5EED_0000 | {22'd0, a[11:2]};
  endfunction

  function automatic logic [31:0] rd(input logic [11:0] a);
    return (written[a[11:2]] === 1'b1) ? mem[a[11:2]] : init_pat(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic do_start(input logic [11:0] b, input logic [10:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that accepted w.
  task automatic send(input logic [31:0] w, input int gap);
    int t = 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge Clk); #1; end
    in_valid = 1'b1; in_data = w;
    while (!in_ready && t < 20) begin @(posedge Clk); #1; t++; end
    @(posedge Clk); #1;
    in_valid = 1'b0;
    chk("send_timeout", 64'(t >= 20), 64'd0);
  endtask

  task automatic step;
    @(posedge Clk); #1;
  endtask

  initial begin
    int wc;
    logic [31:0] w, exp_sum;
    int t;
    Rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_load", mem_enable_load, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_d1", mem_datain1, 0);
    chk("rst_d2", mem_datain2, 0);
`ifdef MEM_INIT_CSUM_EN
    chk("rst_csum", csum, 0);
`endif
    Rst_n = 1'b1;
    step();

    // Four words, two pairs.
    do_start(12'h100, 11'd4);
    chk("t1_busy", busy, 1);
    chk("t1_ready", in_ready, 1);
    send(32'hA0A0_0001, 0);
    send(32'hB0B0_0002, 0);
    chk("t1_p1_wr", mem_wr, 4'hF);
    chk("t1_p1_load", mem_enable_load, 1);
    chk("t1_p1_addr", mem_address, 12'h100);
    chk("t1_p1_d1", mem_datain1, 32'hA0A0_0001);
    chk("t1_p1_d2", mem_datain2, 32'hB0B0_0002);
    chk("t1_p1_ready", in_ready, 0);
    send(32'hC0C0_0003, 0);
    send(32'hD0D0_0004, 0);
    chk("t1_p2_wr", mem_wr, 4'hF);
    chk("t1_p2_load", mem_enable_load, 1);
    chk("t1_p2_addr", mem_address, 12'h108);
    chk("t1_p2_d1", mem_datain1, 32'hC0C0_0003);
    chk("t1_p2_d2", mem_datain2, 32'hD0D0_0004);
    step();
    chk("t1_done", done, 1);
    chk("t1_wr_off", mem_wr, 0);
    chk("t1_load_off", mem_enable_load, 0);
    step();
    chk("t1_done_clr", done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_m100", rd(12'h100), 32'hA0A0_0001);
    chk("t1_m104", rd(12'h104), 32'hB0B0_0002);
    chk("t1_m108", rd(12'h108), 32'hC0C0_0003);
    chk("t1_m10c", rd(12'h10C), 32'hD0D0_0004);
    chk("t1_m110", rd(12'h110), init_pat(12'h110));

    // Three words: pair then single.
    do_start(12'h200, 11'd3);
    send(32'h1111_0005, 0);
    send(32'h2222_0006, 0);
    chk("t2_pair_addr", mem_address, 12'h200);
    chk("t2_pair_load", mem_enable_load, 1);
    send(32'h3333_0007, 0);
    chk("t2_single_wr", mem_wr, 4'hF);
    chk("t2_single_load", mem_enable_load, 0);
    chk("t2_single_addr", mem_address, 12'h208);
    chk("t2_single_d1", mem_datain1, 32'h3333_0007);
    step();
    chk("t2_done", done, 1);
    step();
    chk("t2_m200", rd(12'h200), 32'h1111_0005);
    chk("t2_m204", rd(12'h204), 32'h2222_0006);
    chk("t2_m208", rd(12'h208), 32'h3333_0007);
    chk("t2_m20c", rd(12'h20C), init_pat(12'h20C));

    // Rejections.
    wc = write_cnt;
    do_start(12'hFFC, 11'd2);
    chk("t3_ovf_err", err, 1);
    chk("t3_ovf_busy", busy, 0);
    chk("t3_ovf_ready", in_ready, 0);
    step();
    chk("t3_ovf_err_clr", err, 0);
    do_start(12'h002, 11'd1);
    chk("t3_mis_err", err, 1);
    chk("t3_mis_busy", busy, 0);
    step();
    chk("t3_mis_err_clr", err, 0);
    do_start(12'hFF8, 11'd2);
    chk("t3_edge_ok", err, 0);
    chk("t3_edge_busy", busy, 1);
    send(32'hE0E0_0008, 0);
    send(32'hF0F0_0009, 0);
    chk("t3_edge_addr", mem_address, 12'hFF8);
    repeat (2) step();
    chk("t3_mff8", rd(12'hFF8), 32'hE0E0_0008);
    chk("t3_mffc", rd(12'hFFC), 32'hF0F0_0009);
    wc = write_cnt;

    // Zero-length load.
    do_start(12'h300, 11'd0);
    chk("t4_done", done, 1);
    chk("t4_err", err, 0);
    step();
    chk("t4_done_clr", done, 0);
    chk("t4_no_write", write_cnt, wc);

    // Reset in FILL1.
    do_start(12'h400, 11'd4);
    send(32'h4444_000A, 0);
    chk("t5_fill1_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 32'h5555_000B;
    #2;
    Rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", in_ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_wr", mem_wr, 0);
    chk("t5_rst_load", mem_enable_load, 0);
    chk("t5_rst_addr", mem_address, 0);
    chk("t5_rst_d1", mem_datain1, 0);
    in_valid = 1'b0;
    step();
    chk("t5_rst_hold_wr", mem_wr, 0);
    Rst_n = 1'b1;
    step();
    chk("t5_no_write", write_cnt, wc);
    chk("t5_m400", rd(12'h400), init_pat(12'h400));
    do_start(12'h000, 11'd2);
    send(32'h6666_000C, 0);
    send(32'h7777_000D, 0);
    chk("t5_p_addr", mem_address, 12'h000);
    chk("t5_p_d1", mem_datain1, 32'h6666_000C);
    chk("t5_p_d2", mem_datain2, 32'h7777_000D);
    repeat (2) step();
    chk("t5_m000", rd(12'h000), 32'h6666_000C);
    chk("t5_m004", rd(12'h004), 32'h7777_000D);

    // Seven words with random gaps.
    exp_sum = 32'd0;
    do_start(12'h600, 11'd7);
    for (int i = 0; i < 7; i++) begin
      w = 32'hF000_0000 + 32'(i) * 32'h1357_9BDF;
      exp_sum = exp_sum + w;
      send(w, int'($urandom_range(0, 3)));
    end
    t = 0;
    while (!done && t < 10) begin step(); t++; end
    chk("t6_done_seen", done, 1);
    step();
    for (int i = 0; i < 7; i++) begin
      w = 32'hF000_0000 + 32'(i) * 32'h1357_9BDF;
      chk($sformatf("t6_m%0d", i), rd(12'h600 + 12'(4 * i)), w);
    end
    chk("t6_m61c", rd(12'h61C), init_pat(12'h61C));
`ifdef MEM_INIT_CSUM_EN
    chk("t6_csum", csum, exp_sum);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
